// File: rtl/rr_arbiter_onehot_if.sv
// Grant-side bundle between the round-robin arbiter and its consumer.
// Carries request lines in, and a registered one-hot grant plus binary index out.
// master: requesters/encoder side (drives req, gnt_ready); slave: the arbiter.
interface rr_arbiter_onehot_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     req;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;

  modport master (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_onehot,
    input  gnt_idx,
    input  busy
  );

  modport slave (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_onehot,
    output gnt_idx,
    output busy
  );
endinterface

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter producing a registered, strictly one-hot grant for the 4-to-2 encoder.
// Latency: one register stage from req to gnt_valid; back-to-back grants with no bubble.
// Backpressure: grant is held (sticky, ignores req changes) until gnt_ready accepts it.
// Ports: clk, rst_n (synchronous, active low); bus.slave carries req/gnt_ready in and
//        gnt_valid/gnt_onehot/gnt_idx/busy out. N must be a power of two, IDX_W = clog2(N).
module rr_arbiter_onehot #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arbiter_onehot_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [N-1:0]     gnt_onehot_q;
  logic [N-1:0]     gnt_onehot_nxt;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] gnt_idx_nxt;

  logic             accept;
  logic [IDX_W-1:0] search_ptr;
  logic [N-1:0]     hi_mask;
  logic [N-1:0]     req_hi;
  logic [N-1:0]     winner;
  logic [IDX_W-1:0] winner_idx;

  assign accept = (state == GRANT) && bus.gnt_ready;

  // On an accepting edge the search must already start from the updated pointer,
  // so the freshly served requester drops to lowest priority in the same cycle.
  // N is a power of two, so the IDX_W-bit add wraps modulo N for free.
  assign search_ptr = accept ? (gnt_idx_q + IDX_W'(1)) : ptr;

  // Rotate/mask priority search: first look only at requesters at or above the
  // pointer; if none, fall back to the full vector (the wrapped part). x & -x
  // isolates the lowest set bit, which keeps the winner strictly one-hot.
  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (k >= int'(search_ptr));
    end
    req_hi = bus.req & hi_mask;
    if (req_hi != '0) begin
      winner = req_hi & (~req_hi + N'(1));
    end else begin
      winner = bus.req & (~bus.req + N'(1));
    end
    winner_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (winner[k]) begin
        winner_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    gnt_onehot_nxt = gnt_onehot_q;
    gnt_idx_nxt    = gnt_idx_q;

    case (state)
      IDLE: begin
        if (bus.req != '0) begin
          state_nxt      = GRANT;
          gnt_onehot_nxt = winner;
          gnt_idx_nxt    = winner_idx;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          ptr_nxt = search_ptr;
          if (bus.req != '0) begin
            gnt_onehot_nxt = winner;
            gnt_idx_nxt    = winner_idx;
          end else begin
            state_nxt      = IDLE;
            gnt_onehot_nxt = '0;
            gnt_idx_nxt    = '0;
          end
        end
      end
      default: begin
        state_nxt      = IDLE;
        gnt_onehot_nxt = '0;
        gnt_idx_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      gnt_onehot_q <= gnt_onehot_nxt;
      gnt_idx_q    <= gnt_idx_nxt;
    end
  end

  assign bus.gnt_valid  = (state == GRANT);
  assign bus.busy       = (state == GRANT);
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.gnt_idx    = gnt_idx_q;

endmodule
